// File: rtl/fetch_unit_pkg.sv
// Shared widths and reset defaults for the fetch stage and its instruction memory.
package fetch_unit_pkg;

  // Instruction word width; matches the instr_mem data port.
  localparam int unsigned INST_W = 32;

  localparam int unsigned DEF_PC_W     = 32;
  localparam int unsigned DEF_RESET_PC = 0;

endpackage

// File: rtl/fetch_unit_fifo.sv
// In-order instruction buffer: DEPTH entries, push/pop/flush, and push+pop in the same cycle when full.
module fetch_unit_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign rdata = mem[rd_ptr];

  // Storage is only cleared on reset so id_* never shows X; a flush just rewinds the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (!flush && push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the word-addressed PC, buffers fetched words and hands them to decode over valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [PC_W-1:0]   imem_pc,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              id_valid,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  input  logic              id_ready
);

  logic [PC_W-1:0] pc_q;
  logic            deq;
  logic            pop;
  logic            fetch;
  logic            buf_empty;
  logic            buf_full;

  assign imem_pc  = pc_q;
  assign id_valid = ~buf_empty;
  assign deq      = id_valid & id_ready;

  // A redirect kills any same-cycle acceptance; the flush discards the head anyway.
  assign pop   = deq & ~redirect_valid;
  assign fetch = fetch_en & ~redirect_valid & (~buf_full | deq);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
    end else if (fetch) begin
      pc_q <= pc_q + 1'b1;
    end
  end

  fetch_unit_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (fetch),
    .pop   (pop),
    .wdata ({pc_q, imem_inst}),
    .rdata ({id_pc, id_inst}),
    .empty (buf_empty),
    .full  (buf_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written redirect/reset/wrap sequences, then random traffic against a queue model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned     PC_W     = 32;
  localparam int unsigned     DEPTH    = 2;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fetch_en = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic              id_ready = 1'b0;
  logic [PC_W-1:0]   imem_pc;
  logic [INST_W-1:0] imem_inst;
  logic              id_valid;
  logic [INST_W-1:0] id_inst;
  logic [PC_W-1:0]   id_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W     (PC_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  // Standard program: MOV R0,0 / MOV R1,1 / ADD R0,R0,R1 / SUB R1,R1,1 / NOP / BR -2; filler words elsewhere.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    case (pc)
      32'd0:   return 32'h1000_0000;
      32'd1:   return 32'h1100_0001;
      32'd2:   return 32'h2000_0001;
      32'd3:   return 32'h3101_0001;
      32'd4:   return 32'h0000_0000;
      32'd5:   return 32'hF000_FFFE;
      default: return 32'h5A00_0000 ^ (pc * 32'h9E37_79B1);
    endcase
  endfunction

  assign imem_inst = inst_of(imem_pc);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue of fetched PCs, the fetch address a plain counter.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];

  task automatic model_step();
    bit do_deq;
    bit do_fetch;
    if (rst) begin
      m_q.delete();
      m_pc = RESET_PC;
    end else if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc;
    end else begin
      do_deq   = (m_q.size() > 0) && id_ready;
      do_fetch = fetch_en && ((m_q.size() < int'(DEPTH)) || do_deq);
      if (do_deq) void'(m_q.pop_front());
      if (do_fetch) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd1;
      end
    end
  endtask

  task automatic step(input logic r, input logic fe, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
    rst            = r;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    @(posedge clk);
    #1;
    model_step();
    chk("model_imem_pc", imem_pc, m_pc);
    chk("model_id_valid", id_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("model_id_pc", id_pc, m_q[0]);
      chk("model_id_inst", id_inst, inst_of(m_q[0]));
    end
  endtask

  typedef struct {
    logic        r;
    logic        fe;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eimem;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic fe, logic rv, logic [31:0] rpc, logic rdy,
                              logic ev, logic [31:0] epc, logic [31:0] eimem);
    vec_t v;
    v.r = r; v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eimem = eimem;
    return v;
  endfunction

  initial begin
    // Back-to-back stream with decode always ready.
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 6; k++) vecs.push_back(mk(0, 1, 0, 0, 1, 1, k, k + 1));
    // Decode stalls 5 cycles: buffer fills to 2, PC stops at 2, then drains without a bubble.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 2, 4));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 3, 5));
    // fetch_en low: PC frozen at 5, two buffered entries drain, then fetching resumes from 5.
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 5));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 4, 5));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 5));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 5, 6));
    // Redirect to 3 while the BR at 5 is at the head.
    vecs.push_back(mk(0, 1, 1, 3, 1, 0, 0, 3));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 3, 4));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 4, 5));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 5, 6));

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      chk("vec_id_valid", id_valid, vecs[i].ev);
      chk("vec_imem_pc", imem_pc, vecs[i].eimem);
      if (vecs[i].ev) begin
        chk("vec_id_pc", id_pc, vecs[i].epc);
        chk("vec_id_inst", id_inst, inst_of(vecs[i].epc));
      end
    end

    // Full buffer holding 6/7, redirect coincides with an accepted head: nothing stale may surface.
    step(0, 1, 1, 32'd6, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("full_id_pc", id_pc, 32'd6);
    chk("full_imem_pc", imem_pc, 32'd8);
    step(0, 1, 1, 32'd20, 1);
    chk("redir_flush_valid", id_valid, 1'b0);
    chk("redir_imem_pc", imem_pc, 32'd20);
    step(0, 1, 0, 0, 1);
    chk("redir_first_pc", id_pc, 32'd20);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0, 1);
      chk("no_stale_entry", (id_pc == 32'd6) || (id_pc == 32'd7), 1'b0);
    end

    // Reset wins over a simultaneous redirect and handshake.
    chk("pre_rst_valid", id_valid, 1'b1);
    step(1, 1, 1, 32'd9, 1);
    chk("rst_mid_valid", id_valid, 1'b0);
    chk("rst_mid_imem_pc", imem_pc, RESET_PC);

    // PC wraps from all-ones to zero.
    step(0, 1, 1, 32'hFFFF_FFFF, 0);
    step(0, 1, 0, 0, 0);
    chk("wrap_imem_pc", imem_pc, 32'd0);
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFF);
    step(0, 1, 0, 0, 0);
    chk("wrap_imem_pc_1", imem_pc, 32'd1);
    step(0, 1, 0, 0, 1);
    chk("wrap_next_id_pc", id_pc, 32'd0);

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      logic        r;
      logic        rv;
      logic        fe;
      logic        rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      fe  = ($urandom_range(0, 4) != 0);
      rdy = ($urandom_range(0, 9) < 6);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                        : 32'($urandom_range(0, 50));
      step(r, fe, rv, rpc, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of instr_mem and downstream-feeding the decode stage. Owns the word-addressed program counter and drives it onto instr_mem's combinational read port. Captures the returned instruction word into a small in-order buffer and presents it to decode over a valid/ready handshake. Accepts redirects (taken BR, resolved downstream) that flush buffered work and reload the PC.

Parameters:
PC_W, 32, program-counter width; matches instr_mem pc input.
DEPTH, 2, instruction-buffer entries (power of two, >=2).
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
fetch_en  input  1  global fetch enable; 0 freezes PC and stops new fetches
imem_pc  output  PC_W  address to instr_mem pc; equals pc_q
imem_inst  input  `WIDTH  instruction word from instr_mem, combinational from imem_pc
redirect_valid  input  1  one-cycle pulse: branch taken, discard younger work
redirect_pc  input  PC_W  new fetch address (already pc+sext(imm16) from downstream)
id_valid  output  1  buffer head holds a valid instruction
id_inst  output  `WIDTH  head instruction word
id_pc  output  PC_W  PC of head instruction
id_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (rst=1 at edge): pc_q<=RESET_PC, buffer count<=0, rd/wr pointers<=0. Outputs after reset: imem_pc=RESET_PC, id_valid=0, id_inst/id_pc = don't-care but must not be X in sim (clear storage to 0). rst dominates every other input, including mid-redirect or mid-handshake.
- pc_q is word-addressed; sequential increment is +1, PC_W-bit wrap-around (all-ones -> 0), no trap.
- deq = id_valid & id_ready. fetch = fetch_en & ~redirect_valid & (count<DEPTH | deq).
- On fetch: entry {imem_inst, pc_q} written at wr pointer; pc_q<=pc_q+1. Fetch latency: instruction at PC p appears on id_* the cycle after imem_pc=p (buffer empty case); zero-bubble back-to-back when id_ready held high.
- Full buffer with deq in same cycle: fetch still occurs (simultaneous read/write, count unchanged).
- Empty buffer: id_valid=0; id_ready ignored. No combinational bypass from imem_inst to id_inst.
- id_inst/id_pc stable while id_valid=1 and id_ready=0.
- Redirect (redirect_valid=1): highest priority below rst. Next edge: count<=0, pointers<=0, pc_q<=redirect_pc; no fetch and no deq counted that cycle (id_valid may be high; decode must treat same-cycle acceptance as killed—redirect wins). First redirected instruction valid at id_* two cycles after redirect pulse.
- fetch_en=0: pc_q held, buffer drains normally through deq; redirect still honoured (PC loaded, buffer flushed).
- Count is 0..DEPTH, width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- State summary (derived from count): EMPTY (0), PARTIAL, FULL (DEPTH); transitions per fetch/deq/redirect as above.

Decomposition:
- defines.vh supplies `WIDTH and opcode constants; add `PC_W default and `RESET_PC there so instr_mem and fetch_unit agree.
- One natural sub-module: fetch_fifo (DEPTH-entry synchronous FIFO, payload {pc, inst}, push/pop/flush, full/empty, same-cycle push+pop when full). fetch_unit keeps PC logic and handshake glue.

Test Plan:
- Reset then fetch_en=1, id_ready=1, with the standard 6-word program -> id_pc 0,1,2,3,4,5 on consecutive cycles from cycle 1 after reset; id_inst matches MOV R0,0 ... BR -2.
- id_ready=0 for 5 cycles after reset -> id_valid=1, id_pc held 0, buffer fills to 2, imem_pc stops at 2; release id_ready -> id_pc 0,1,2 with no bubble.
- Redirect pulse with redirect_pc=3 while id_pc=5 (BR) -> buffer flushed, imem_pc=3 next cycle, id_pc=3 valid two cycles after pulse, then 4,5.
- Redirect same cycle as id_valid&id_ready and full buffer -> count 0 next cycle, no stale entry (pc 6/7) ever appears on id_pc.
- fetch_en=0 with 2 buffered entries -> those 2 drain, imem_pc frozen, id_valid drops; fetch_en=1 resumes from frozen PC.
- rst asserted mid-stream with id_valid=1 and redirect_valid=1 -> next cycle id_valid=0, imem_pc=RESET_PC; PC_W=4 variant with pc 15 -> wraps to 0.
